// File: rtl/ws281x_decode_if.sv
// Byte-lane write port produced by the WS281x receiver, shaped like the LED layer RAM write side.
// The decoder drives it through the master modport; a RAM or checker listens through the slave modport.
interface ws281x_decode_if #(
   parameter int ADDR_WIDTH = 6
);
   logic                  wr_en_out;
   logic [ADDR_WIDTH-1:0] wr_addr_out;
   logic [7:0]            wr_data_out;
   logic [3:0]            wr_byte_en_out;
   logic                  wr_done_out;
   logic                  frame_err_out;

   modport master (
      output wr_en_out,
      output wr_addr_out,
      output wr_data_out,
      output wr_byte_en_out,
      output wr_done_out,
      output frame_err_out
   );

   modport slave (
      input wr_en_out,
      input wr_addr_out,
      input wr_data_out,
      input wr_byte_en_out,
      input wr_done_out,
      input frame_err_out
   );
endinterface

// File: rtl/ws281x_decode.sv
// WS281x line receiver: classifies high-pulse widths into bits and writes MSB-first bytes into 32-bit word lanes.
// Define WS281X_DECODE_STAT_EN to add per-frame byte_cnt_out / glitch_cnt_out statistics.
//
// state      | meaning
// S_WAIT_RST | waiting for a low gap of rst_cnt_in cycles before decoding
// S_IDLE     | line low between bits; watches for rise or end-of-frame gap
// S_HIGH     | line high; pulse width measured, classified on the falling edge
module ws281x_decode #(
   parameter int SYNC_STAGES = 2,
   parameter int ADDR_WIDTH  = 6
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        ws281x_code_in,
   input  logic [7:0]  bit_thr_in,
   input  logic [7:0]  min_high_in,
   input  logic [15:0] rst_cnt_in,
   ws281x_decode_if.master wr_if
`ifdef WS281X_DECODE_STAT_EN
   ,
   output logic [ADDR_WIDTH+2:0] byte_cnt_out,
   output logic [7:0]            glitch_cnt_out
`endif
);

   typedef enum logic [1:0] {
      S_WAIT_RST = 2'd0,
      S_IDLE     = 2'd1,
      S_HIGH     = 2'd2
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line_s, line_d;
   logic                   rise, fall;
   logic [7:0]             high_cnt;
   logic [15:0]            low_cnt;
   logic [15:0]            rst_eff;

   logic [7:0]            shreg;
   logic [2:0]            bit_cnt;
   logic [1:0]            byte_idx;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  full;
   logic                  frame_active;
   logic                  clr_pend;

   logic       leave_wait, stuck, frame_end, shift_en, glitch_ev, err_clr;
   logic       bit_val;
   logic [7:0] shreg_nxt;

   assign line_s    = sync_q[SYNC_STAGES-1];
   assign rise      = line_s & ~line_d;
   assign fall      = ~line_s & line_d;
   assign rst_eff   = (rst_cnt_in == 16'd0) ? 16'd1 : rst_cnt_in;
   assign bit_val   = (high_cnt >= bit_thr_in);
   assign shreg_nxt = {shreg[6:0], bit_val};

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_q   <= '0;
         line_d   <= 1'b0;
         high_cnt <= 8'd0;
         low_cnt  <= 16'd0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], ws281x_code_in};
         line_d <= line_s;
         if (rise)
            high_cnt <= 8'd1;
         else if (line_s && high_cnt != 8'hFF)
            high_cnt <= high_cnt + 8'd1;
         if (fall)
            low_cnt <= 16'd1;
         else if (!line_s && low_cnt != 16'hFFFF)
            low_cnt <= low_cnt + 16'd1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state_q <= S_WAIT_RST;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_WAIT_RST: if (leave_wait) state_d = S_IDLE;
         S_IDLE:     if (rise) state_d = S_HIGH;
         S_HIGH: begin
            if (stuck)
               state_d = S_WAIT_RST;
            else if (fall)
               state_d = S_IDLE;
         end
         default:    state_d = S_WAIT_RST;
      endcase
   end

   // On the fall cycle low_cnt still holds the previous gap, so it must not qualify a wait exit.
   always_comb begin
      leave_wait = (state_q == S_WAIT_RST) && !line_s && !fall && (low_cnt >= rst_eff);
      stuck      = (state_q == S_HIGH) && line_s && (high_cnt == 8'hFF);
      frame_end  = (state_q == S_IDLE) && !line_s && frame_active && (low_cnt == rst_eff);
      shift_en   = (state_q == S_HIGH) && fall && (high_cnt >= min_high_in);
      glitch_ev  = (state_q == S_HIGH) && fall && (high_cnt < min_high_in);
      err_clr    = (state_q == S_IDLE) && rise && clr_pend;
   end

`ifdef WS281X_DECODE_STAT_EN
   logic [ADDR_WIDTH+2:0] bytes_wr;
   logic [7:0]            glitch_frm;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         shreg                <= 8'd0;
         bit_cnt              <= 3'd0;
         byte_idx             <= 2'd0;
         addr                 <= '0;
         full                 <= 1'b0;
         frame_active         <= 1'b0;
         clr_pend             <= 1'b0;
         wr_if.wr_en_out      <= 1'b0;
         wr_if.wr_addr_out    <= '0;
         wr_if.wr_data_out    <= 8'd0;
         wr_if.wr_byte_en_out <= 4'd0;
         wr_if.wr_done_out    <= 1'b0;
         wr_if.frame_err_out  <= 1'b0;
`ifdef WS281X_DECODE_STAT_EN
         bytes_wr       <= '0;
         glitch_frm     <= 8'd0;
         byte_cnt_out   <= '0;
         glitch_cnt_out <= 8'd0;
`endif
      end else begin
         wr_if.wr_en_out   <= 1'b0;
         wr_if.wr_done_out <= 1'b0;
         if (wr_if.wr_done_out || err_clr)
            wr_if.frame_err_out <= 1'b0;
         if (leave_wait)
            clr_pend <= 1'b1;
         else if (err_clr)
            clr_pend <= 1'b0;

         if (stuck || frame_end) begin
            shreg        <= 8'd0;
            bit_cnt      <= 3'd0;
            byte_idx     <= 2'd0;
            addr         <= '0;
            full         <= 1'b0;
            frame_active <= 1'b0;
`ifdef WS281X_DECODE_STAT_EN
            bytes_wr   <= '0;
            glitch_frm <= 8'd0;
`endif
         end

         if (stuck)
            wr_if.frame_err_out <= 1'b1;

         if (frame_end) begin
            wr_if.wr_done_out <= 1'b1;
            if (bit_cnt != 3'd0)
               wr_if.frame_err_out <= 1'b1;
`ifdef WS281X_DECODE_STAT_EN
            byte_cnt_out   <= bytes_wr;
            glitch_cnt_out <= glitch_frm;
`endif
         end

`ifdef WS281X_DECODE_STAT_EN
         if (glitch_ev && glitch_frm != 8'hFF)
            glitch_frm <= glitch_frm + 8'd1;
`endif

         if (shift_en) begin
            shreg        <= shreg_nxt;
            bit_cnt      <= bit_cnt + 3'd1;
            frame_active <= 1'b1;
            if (bit_cnt == 3'd7) begin
               // Once the last lane of the last word is written, further bytes only flag an error.
               if (full) begin
                  wr_if.frame_err_out <= 1'b1;
               end else begin
                  wr_if.wr_en_out      <= 1'b1;
                  wr_if.wr_data_out    <= shreg_nxt;
                  wr_if.wr_addr_out    <= addr;
                  wr_if.wr_byte_en_out <= 4'b1000 >> byte_idx;
                  byte_idx             <= byte_idx + 2'd1;
`ifdef WS281X_DECODE_STAT_EN
                  bytes_wr <= bytes_wr + 1'b1;
`endif
                  if (byte_idx == 2'd3) begin
                     if (addr == ADDR_MAX)
                        full <= 1'b1;
                     else
                        addr <= addr + 1'b1;
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_ws281x_decode.sv
// Bench for ws281x_decode: table of frames with random payloads checked against an address/lane model,
// plus hand-written stuck-high and mid-frame reset sequences.
module tb_ws281x_decode;
   localparam int CAP = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        line = 1'b0;
   logic [7:0]  bit_thr = 8'd30;
   logic [7:0]  min_high = 8'd5;
   logic [15:0] rst_cnt = 16'd2500;

   always #5 clk = ~clk;

   ws281x_decode_if #(.ADDR_WIDTH(6)) bus ();

`ifdef WS281X_DECODE_STAT_EN
   logic [8:0] byte_cnt;
   logic [7:0] glitch_cnt;
`endif

   ws281x_decode #(.SYNC_STAGES(2), .ADDR_WIDTH(6)) dut (
      .clk_in         (clk),
      .rst_n_in       (rst_n),
      .ws281x_code_in (line),
      .bit_thr_in     (bit_thr),
      .min_high_in    (min_high),
      .rst_cnt_in     (rst_cnt),
      .wr_if          (bus)
`ifdef WS281X_DECODE_STAT_EN
      ,
      .byte_cnt_out   (byte_cnt),
      .glitch_cnt_out (glitch_cnt)
`endif
   );

   // Monitor: logs every write strobe and done pulse; written only here.
   logic [17:0] wr_log[$];
   int          done_cnt = 0;
   int          overlap_cnt = 0;
   logic        err_at_done = 1'b0;
   logic        err_after = 1'b1;
   logic        after_done = 1'b0;

   always @(negedge clk) begin
      if (after_done) err_after = bus.frame_err_out;
      after_done = bus.wr_done_out;
      if (bus.wr_en_out) wr_log.push_back({bus.wr_addr_out, bus.wr_byte_en_out, bus.wr_data_out});
      if (bus.wr_done_out) begin
         done_cnt++;
         err_at_done = bus.frame_err_out;
      end
      if (bus.wr_en_out && bus.wr_done_out) overlap_cnt++;
   end

   int n_checks = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic lvl, input int n);
      line = lvl;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_mode(input bit fast);
      bit_thr  = fast ? 8'd10 : 8'd30;
      min_high = fast ? 8'd3 : 8'd5;
      rst_cnt  = fast ? 16'd200 : 16'd2500;
   endtask

   task automatic send_bit(input logic b, input bit fast);
      if (fast) begin
         hold(1'b1, b ? 12 : 4);
         hold(1'b0, 3);
      end else begin
         hold(1'b1, b ? 40 : 20);
         hold(1'b0, b ? 25 : 45);
      end
   endtask

   task automatic send_glitch(input bit fast);
      hold(1'b1, fast ? 2 : 3);
      hold(1'b0, fast ? 3 : 20);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit fast, input bit glitch);
      for (int i = 7; i >= 0; i--) begin
         send_bit(b[i], fast);
         if (glitch && i == 4) send_glitch(fast);
      end
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, " wr_en"},   32'(bus.wr_en_out), 32'd0);
      check({tag, " wr_done"}, 32'(bus.wr_done_out), 32'd0);
      check({tag, " addr"},    32'(bus.wr_addr_out), 32'd0);
      check({tag, " data"},    32'(bus.wr_data_out), 32'd0);
      check({tag, " byte_en"}, 32'(bus.wr_byte_en_out), 32'd0);
      check({tag, " err"},     32'(bus.frame_err_out), 32'd0);
   endtask

   // Reference: byte i of a frame lands in word i/4, lane counted from the top of the word.
   function automatic logic [17:0] model_write(input int i, input logic [7:0] d);
      logic [5:0] a;
      logic [3:0] lane;
      a    = 6'(i / 4);
      lane = 4'(1 << (3 - (i % 4)));
      return {a, lane, d};
   endfunction

   typedef struct {
      int          nbytes;
      int          extra_bits;
      bit          fixed_data;
      logic [31:0] fixed;
      bit          glitch;
      bit          fast;
      int          exp_writes;
      logic        exp_err;
      logic [5:0]  exp_last_addr;
      logic [3:0]  exp_last_lane;
   } vec_t;

   vec_t       vecs[7];
   logic [7:0] bytes[$];
   int         base_wr, base_done, n_got, exp_n;
   logic [31:0] fx;

   initial begin
      vecs[0] = '{4,   0, 1'b1, 32'hA53CFF00, 1'b0, 1'b0, 4,   1'b0, 6'd0,  4'h1};
      vecs[1] = '{6,   0, 1'b0, 32'h0,        1'b0, 1'b0, 6,   1'b0, 6'd1,  4'h4};
      vecs[2] = '{1,   0, 1'b1, 32'h81000000, 1'b1, 1'b0, 1,   1'b0, 6'd0,  4'h8};
      vecs[3] = '{1,   4, 1'b0, 32'h0,        1'b0, 1'b0, 1,   1'b1, 6'd0,  4'h8};
      vecs[4] = '{257, 0, 1'b0, 32'h0,        1'b0, 1'b1, 256, 1'b1, 6'd63, 4'h1};
      vecs[5] = '{3,   0, 1'b0, 32'h0,        1'b1, 1'b1, 3,   1'b0, 6'd0,  4'h2};
      vecs[6] = '{0,   5, 1'b0, 32'h0,        1'b0, 1'b0, 0,   1'b1, 6'd0,  4'h0};

      set_mode(1'b0);
      @(posedge clk);
      #2;
      hold(1'b0, 3);
      check_outputs_zero("in_reset");
      rst_n = 1'b1;
      hold(1'b0, 3000);
      check("post_reset wr_en", 32'(bus.wr_en_out), 32'd0);
      check("post_reset done_cnt", 32'(done_cnt), 32'd0);
      check("post_reset err", 32'(bus.frame_err_out), 32'd0);

      for (int r = 0; r < 7; r++) begin
         set_mode(vecs[r].fast);
         bytes.delete();
         fx = vecs[r].fixed;
         for (int i = 0; i < vecs[r].nbytes; i++) begin
            if (vecs[r].fixed_data) bytes.push_back(fx[31 - 8 * i -: 8]);
            else bytes.push_back(8'($urandom));
         end
         base_wr   = wr_log.size();
         base_done = done_cnt;
         foreach (bytes[i]) send_byte(bytes[i], vecs[r].fast, vecs[r].glitch);
         for (int e = 0; e < vecs[r].extra_bits; e++) send_bit(1'($urandom_range(0, 1)), vecs[r].fast);
         hold(1'b0, int'(rst_cnt) + 200);

         n_got = wr_log.size() - base_wr;
         exp_n = (vecs[r].nbytes < CAP) ? vecs[r].nbytes : CAP;
         check($sformatf("row%0d n_writes", r), 32'(n_got), 32'(vecs[r].exp_writes));
         for (int i = 0; i < exp_n && i < n_got; i++)
            check($sformatf("row%0d write%0d", r, i), 32'(wr_log[base_wr + i]), 32'(model_write(i, bytes[i])));
         if (vecs[r].exp_writes > 0 && n_got > 0)
            check($sformatf("row%0d last_addr_lane", r), 32'(wr_log[base_wr + n_got - 1][17:8]),
                  32'({vecs[r].exp_last_addr, vecs[r].exp_last_lane}));
         check($sformatf("row%0d done_pulses", r), 32'(done_cnt - base_done), 32'd1);
         check($sformatf("row%0d err_at_done", r), 32'(err_at_done), 32'(vecs[r].exp_err));
         check($sformatf("row%0d err_after_done", r), 32'(err_after), 32'd0);
      end

      // Stuck-high mid-byte, then traffic that must be ignored until a full reset gap.
      set_mode(1'b0);
      base_wr   = wr_log.size();
      base_done = done_cnt;
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      hold(1'b1, 300);
      hold(1'b0, 1000);
      send_byte(8'h5A, 1'b0, 1'b0);
      hold(1'b0, 2700);
      check("stuck writes", 32'(wr_log.size() - base_wr), 32'd0);
      check("stuck done", 32'(done_cnt - base_done), 32'd0);
      check("stuck err", 32'(bus.frame_err_out), 32'd1);
      send_byte(8'hC3, 1'b0, 1'b0);
      hold(1'b0, 2700);
      check("resume writes", 32'(wr_log.size() - base_wr), 32'd1);
      if (wr_log.size() > base_wr)
         check("resume write0", 32'(wr_log[base_wr]), 32'(model_write(0, 8'hC3)));
      check("resume done", 32'(done_cnt - base_done), 32'd1);
      check("resume err_at_done", 32'(err_at_done), 32'd0);

      // Reset in the middle of a frame: outputs clear at once and nothing pending escapes.
      send_byte(8'h3C, 1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      check("pre_reset data", 32'(bus.wr_data_out), 32'h3C);
      base_wr   = wr_log.size();
      base_done = done_cnt;
      rst_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      hold(1'b0, 3);
      rst_n = 1'b1;
      hold(1'b0, 2700);
      check("after_reset writes", 32'(wr_log.size() - base_wr), 32'd0);
      check("after_reset done", 32'(done_cnt - base_done), 32'd0);

      bytes.delete();
      bytes.push_back(8'($urandom));
      bytes.push_back(8'($urandom));
      base_wr   = wr_log.size();
      base_done = done_cnt;
      foreach (bytes[i]) send_byte(bytes[i], 1'b0, 1'b0);
      hold(1'b0, 2700);
      check("final n_writes", 32'(wr_log.size() - base_wr), 32'd2);
      for (int i = 0; i < 2 && base_wr + i < wr_log.size(); i++)
         check($sformatf("final write%0d", i), 32'(wr_log[base_wr + i]), 32'(model_write(i, bytes[i])));
      check("final done", 32'(done_cnt - base_done), 32'd1);
      check("strobe overlap", 32'(overlap_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
